// File: rtl/dcm_ctrl_pkg.sv
// Shared definitions for the DCM lock supervisor: FSM encodings, the status bit
// index and the cycle counter width.
package dcm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PULSE  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam int STAT_CLKFX_STOPPED = 2;
  localparam int CNT_W              = 15;

  // Retry counter increment that holds at all-ones instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/dcm_lock_ctrl_sync2.sv
// Two-flop synchroniser for a single bit arriving asynchronously to i_clk.
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Double-register the input; both stages clear to 0 on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dcm_lock_ctrl.sv
// DCM lock supervisor: pulses the DCM reset, waits for lock, qualifies stability,
// retries on failure and latches a fault. Runs only on the free-running input clock.
module dcm_lock_ctrl
  import dcm_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 24000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       i_clkin,
  input  logic       i_rst,
  input  logic       i_dcm_locked,
  input  logic [7:0] i_dcm_status,
  input  logic       i_force_relock,
  output logic       o_dcm_rst,
  output logic       o_clk_ok,
  output logic       o_sys_rst,
  output logic       o_fault,
  output logic [3:0] o_retries,
  output logic [2:0] o_state
);

  localparam logic [CNT_W-1:0] L_RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       L_RETRY_LIMIT = 4'(MAX_RETRIES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retries;
  logic             r_dcm_rst;
  logic             r_clk_ok;
  logic             r_sys_rst;
  logic             r_fault;

  logic   w_locked_s;
  logic   w_fxstop_s;
  logic   w_good;
  logic   w_fail;
  logic   w_unused_status;
  logic [3:0] w_retries_inc;
  state_t w_fail_state;

  sync2 u_sync_locked (
    .i_clk (i_clkin),
    .i_rst (i_rst),
    .i_d   (i_dcm_locked),
    .o_q   (w_locked_s)
  );

  sync2 u_sync_fxstop (
    .i_clk (i_clkin),
    .i_rst (i_rst),
    .i_d   (i_dcm_status[STAT_CLKFX_STOPPED]),
    .o_q   (w_fxstop_s)
  );

  assign w_good          = w_locked_s & ~w_fxstop_s;
  assign w_unused_status = |{i_dcm_status[7:3], i_dcm_status[1:0]};

  // Failure detection and the retry/fault decision taken on a failure.
  always_comb begin
    w_fail        = 1'b0;
    w_retries_inc = sat_inc4(r_retries);
    w_fail_state  = ST_PULSE;
    case (r_state)
      ST_WAIT:   w_fail = ~w_good & (r_cnt == L_TMO_LAST);
      ST_STABLE: w_fail = ~w_good;
      ST_RUN:    w_fail = ~w_good;
      default:   w_fail = 1'b0;
    endcase
    if (w_retries_inc == L_RETRY_LIMIT) begin
      w_fail_state = ST_FAULT;
    end else begin
      w_fail_state = ST_PULSE;
    end
  end

  // Lock-sequencing FSM with registered outputs; FORCE_RELOCK outranks everything.
  always_ff @(posedge i_clkin or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_PULSE;
      r_cnt     <= '0;
      r_retries <= 4'd0;
      r_dcm_rst <= 1'b1;
      r_clk_ok  <= 1'b0;
      r_sys_rst <= 1'b1;
      r_fault   <= 1'b0;
    end else if (i_force_relock) begin
      r_state   <= ST_PULSE;
      r_cnt     <= '0;
      r_retries <= 4'd0;
      r_dcm_rst <= 1'b1;
      r_clk_ok  <= 1'b0;
      r_sys_rst <= 1'b1;
      r_fault   <= 1'b0;
    end else if (w_fail) begin
      r_state   <= w_fail_state;
      r_cnt     <= '0;
      r_retries <= w_retries_inc;
      r_dcm_rst <= 1'b1;
      r_clk_ok  <= 1'b0;
      r_sys_rst <= 1'b1;
      r_fault   <= (w_fail_state == ST_FAULT);
    end else begin
      case (r_state)
        ST_PULSE: begin
          if (r_cnt == L_RST_LAST) begin
            r_state   <= ST_WAIT;
            r_cnt     <= '0;
            r_dcm_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 15'd1;
          end
        end
        ST_WAIT: begin
          if (w_good) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 15'd1;
          end
        end
        ST_STABLE: begin
          if (r_cnt == L_STB_LAST) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_retries <= 4'd0;
            r_clk_ok  <= 1'b1;
            r_sys_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 15'd1;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt;
        end
        ST_FAULT: begin
          r_dcm_rst <= 1'b1;
          r_fault   <= 1'b1;
          r_clk_ok  <= 1'b0;
          r_sys_rst <= 1'b1;
        end
        default: begin
          r_state   <= ST_PULSE;
          r_cnt     <= '0;
          r_dcm_rst <= 1'b1;
          r_clk_ok  <= 1'b0;
          r_sys_rst <= 1'b1;
        end
      endcase
    end
  end

  assign o_dcm_rst = r_dcm_rst;
  assign o_clk_ok  = r_clk_ok;
  assign o_sys_rst = r_sys_rst;
  assign o_fault   = r_fault;
  assign o_retries = r_retries;
  assign o_state   = r_state;

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// Directed bench for dcm_lock_ctrl: expected values are queued as each step is
// driven and popped when the corresponding DUT response is measured.
module tb_dcm_lock_ctrl;

  localparam int P_RST = 4;
  localparam int P_TMO = 100;
  localparam int P_STB = 16;
  localparam int P_MAX = 3;
  localparam int SEL_DCM_RST = 0;
  localparam int SEL_CLK_OK  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       force_relock = 1'b0;
  logic [7:0] status = 8'h00;
  logic       dcm_rst, clk_ok, sys_rst, fault;
  logic [3:0] retries;
  logic [2:0] state;

  always #5 clk = ~clk;

  dcm_lock_ctrl #(
    .RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT  (P_TMO),
    .STABLE_CYCLES (P_STB),
    .MAX_RETRIES   (P_MAX)
  ) dut (
    .i_clkin        (clk),
    .i_rst          (rst),
    .i_dcm_locked   (locked),
    .i_dcm_status   (status),
    .i_force_relock (force_relock),
    .o_dcm_rst      (dcm_rst),
    .o_clk_ok       (clk_ok),
    .o_sys_rst      (sys_rst),
    .o_fault        (fault),
    .o_retries      (retries),
    .o_state        (state)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  n;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t it;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed=%0d with no expectation queued", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s: observed=%0d expected=%0d", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      SEL_DCM_RST: return dcm_rst;
      SEL_CLK_OK:  return clk_ok;
      default:     return 1'bx;
    endcase
  endfunction

  // Edges until the selected output reaches val; -1 if the bound expires.
  task automatic cycles_until(input int sel, input logic val, output int cnt);
    cnt = -1;
    for (int k = 1; k <= 1000; k++) begin
      cyc(1);
      if (pick(sel) === val) begin
        cnt = k;
        break;
      end
    end
  endtask

  task automatic check_all(input string pfx, input logic dr, input logic ok,
                           input logic sr, input logic flt, input logic [3:0] rt,
                           input logic [2:0] st);
    push({pfx, "_dcm_rst"}, 32'(dr));  chk(32'(dcm_rst));
    push({pfx, "_clk_ok"},  32'(ok));  chk(32'(clk_ok));
    push({pfx, "_sys_rst"}, 32'(sr));  chk(32'(sys_rst));
    push({pfx, "_fault"},   32'(flt)); chk(32'(fault));
    push({pfx, "_retries"}, 32'(rt));  chk(32'(retries));
    push({pfx, "_state"},   32'(st));  chk(32'(state));
  endtask

  task automatic pulse_force();
    force_relock = 1'b1;
    cyc(1);
    force_relock = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    cyc(3);
    check_all("reset", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0);

    // Normal lock
    rst = 1'b0;
    push("norm_pulse_len", 32'(P_RST));
    cycles_until(SEL_DCM_RST, 1'b0, n); chk(32'(n));
    push("norm_state_wait", 32'd1); chk(32'(state));
    cyc(20);
    locked = 1'b1;
    push("norm_lock_lat", 32'(2 + P_STB + 1));
    cycles_until(SEL_CLK_OK, 1'b1, n); chk(32'(n));
    check_all("norm_run", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd3);

    // Unused status bits must not disturb RUN
    status = 8'hFB;
    cyc(5);
    push("stat_other_bits_clk_ok", 32'd1); chk(32'(clk_ok));
    status = 8'h00;

    // Loss of lock in RUN
    locked = 1'b0;
    push("loss_lat", 32'd3);
    cycles_until(SEL_CLK_OK, 1'b0, n); chk(32'(n));
    check_all("loss", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 3'd0);
    push("loss_pulse_len", 32'(P_RST));
    cycles_until(SEL_DCM_RST, 1'b0, n); chk(32'(n));
    locked = 1'b1;
    push("loss_relock_lat", 32'(2 + P_STB + 1));
    cycles_until(SEL_CLK_OK, 1'b1, n); chk(32'(n));
    push("loss_relock_retries", 32'd0); chk(32'(retries));

    // CLKFX stopped while locked
    status = 8'h04;
    push("fx_lat", 32'd3);
    cycles_until(SEL_CLK_OK, 1'b0, n); chk(32'(n));
    check_all("fx", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 3'd0);
    status = 8'h00;
    push("fx_pulse_len", 32'(P_RST));
    cycles_until(SEL_DCM_RST, 1'b0, n); chk(32'(n));
    push("fx_relock_lat", 32'(1 + P_STB));
    cycles_until(SEL_CLK_OK, 1'b1, n); chk(32'(n));
    push("fx_relock_retries", 32'd0); chk(32'(retries));

    // Unstable lock: glitch during STABLE
    locked = 1'b0;
    pulse_force();
    check_all("ustb_force", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0);
    push("ustb_pulse_len", 32'(P_RST));
    cycles_until(SEL_DCM_RST, 1'b0, n); chk(32'(n));
    locked = 1'b1;
    cyc(10);
    locked = 1'b0;
    cyc(1);
    locked = 1'b1;
    push("ustb_in_stable", 32'd2); chk(32'(state));
    push("ustb_fail_lat", 32'd2);
    cycles_until(SEL_DCM_RST, 1'b1, n); chk(32'(n));
    check_all("ustb_fail", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 3'd0);
    push("ustb_pulse2_len", 32'(P_RST));
    cycles_until(SEL_DCM_RST, 1'b0, n); chk(32'(n));
    push("ustb_relock_lat", 32'(1 + P_STB));
    cycles_until(SEL_CLK_OK, 1'b1, n); chk(32'(n));
    push("ustb_relock_retries", 32'd0); chk(32'(retries));

    // Timeout retries leading to FAULT
    locked = 1'b0;
    pulse_force();
    for (int i = 0; i < P_MAX; i++) begin
      push("tmo_pulse_len", 32'(P_RST));
      cycles_until(SEL_DCM_RST, 1'b0, n); chk(32'(n));
      push("tmo_wait_len", 32'(P_TMO));
      cycles_until(SEL_DCM_RST, 1'b1, n); chk(32'(n));
      push("tmo_retries", 32'(i + 1)); chk(32'(retries));
      push("tmo_fault", 32'((i == P_MAX - 1) ? 1 : 0)); chk(32'(fault));
    end
    cyc(20);
    check_all("fault_hold", 1'b1, 1'b0, 1'b1, 1'b1, 4'(P_MAX), 3'd4);

    // Recovery from FAULT via FORCE_RELOCK
    pulse_force();
    check_all("rec_force", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0);
    push("rec_pulse_len", 32'(P_RST));
    cycles_until(SEL_DCM_RST, 1'b0, n); chk(32'(n));
    locked = 1'b1;
    push("rec_lock_lat", 32'(2 + P_STB + 1));
    cycles_until(SEL_CLK_OK, 1'b1, n); chk(32'(n));
    push("rec_fault", 32'd0); chk(32'(fault));

    // RST asserted mid-WAIT
    locked = 1'b0;
    push("rstw_loss_lat", 32'd3);
    cycles_until(SEL_CLK_OK, 1'b0, n); chk(32'(n));
    push("rstw_pulse_len", 32'(P_RST));
    cycles_until(SEL_DCM_RST, 1'b0, n); chk(32'(n));
    cyc(5);
    push("rstw_in_wait", 32'd1); chk(32'(state));
    push("rstw_pre_retries", 32'd1); chk(32'(retries));
    rst = 1'b1;
    #1;
    check_all("rstw_async", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0);
    cyc(2);
    rst = 1'b0;
    push("rstw_pulse2_len", 32'(P_RST));
    cycles_until(SEL_DCM_RST, 1'b0, n); chk(32'(n));
    locked = 1'b1;
    push("rstw_lock_lat", 32'(2 + P_STB + 1));
    cycles_until(SEL_CLK_OK, 1'b1, n); chk(32'(n));
    check_all("rstw_run", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
